id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_if.sv | 41 ++++
 rtl/id_ex_stage.sv | 86 ++++++++
 tb/tb_id_ex_stage.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline register bundle: decoded ID-stage inputs, registered EX-stage
// outputs, load-use stall request and event counters.
interface id_ex_stage_if;
    logic        flush_i;
    logic [12:0] id_ctrl_i;
    logic [31:0] id_pc4_i;
    logic [31:0] id_rs_data_i;
    logic [31:0] id_rt_data_i;
    logic [31:0] id_imm_i;
    logic [4:0]  id_rs_i;
    logic [4:0]  id_rt_i;
    logic [4:0]  id_rd_i;
    logic [5:0]  id_funct_i;

    logic [12:0] ex_ctrl_o;
    logic [31:0] ex_pc4_o;
    logic [31:0] ex_rs_data_o;
    logic [31:0] ex_rt_data_o;
    logic [31:0] ex_imm_o;
    logic [4:0]  ex_rs_o;
    logic [4:0]  ex_rt_o;
    logic [4:0]  ex_rd_o;
    logic [5:0]  ex_funct_o;
    logic        stall_o;
    logic [15:0] bubble_cnt_o;
    logic [15:0] flush_cnt_o;

    modport master (
        output flush_i, id_ctrl_i, id_pc4_i, id_rs_data_i, id_rt_data_i, id_imm_i,
               id_rs_i, id_rt_i, id_rd_i, id_funct_i,
        input  ex_ctrl_o, ex_pc4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o,
               ex_rs_o, ex_rt_o, ex_rd_o, ex_funct_o, stall_o, bubble_cnt_o, flush_cnt_o
    );

    modport slave (
        input  flush_i, id_ctrl_i, id_pc4_i, id_rs_data_i, id_rt_data_i, id_imm_i,
               id_rs_i, id_rt_i, id_rd_i, id_funct_i,
        output ex_ctrl_o, ex_pc4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o,
               ex_rs_o, ex_rt_o, ex_rd_o, ex_funct_o, stall_o, bubble_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// hazard or flush, and saturating bubble/flush event counters.
// Control packing: {RegWrite, ALU_op[3:0], ALUSrc, RegDst, Branch, Jump,
//                   MemRead, MemWrite, MemtoReg, reserved}
module id_ex_stage (
    input  logic           clk_i,
    input  logic           rst_i,
    id_ex_stage_if.slave   bus_io
);
    // MemtoReg=1 is the non-load value; everything else inert.
    localparam logic [12:0] BUBBLE_CTRL = 13'b0_0000_0000_0010;
    localparam int          MEMREAD_BIT = 3;

    logic [12:0] ctrl_q,    ctrl_d;
    logic [31:0] pc4_q,     rs_data_q, rt_data_q, imm_q;
    logic [4:0]  rs_q,      rt_q,      rd_q;
    logic [5:0]  funct_q;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    logic [15:0] flush_cnt_q,  flush_cnt_d;
    logic        hazard;

    // Load in EX whose destination (not $0) is read by the instruction in ID.
    always_comb begin
        hazard = ctrl_q[MEMREAD_BIT] && (rt_q != 5'd0) &&
                 ((rt_q == bus_io.id_rs_i) || (rt_q == bus_io.id_rt_i));
    end

    // Next control word and counters; flush outranks hazard.
    always_comb begin
        ctrl_d       = bus_io.id_ctrl_i;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (bus_io.flush_i) begin
            ctrl_d = BUBBLE_CTRL;
            if (flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
        end else if (hazard) begin
            ctrl_d = BUBBLE_CTRL;
            if (bubble_cnt_q != 16'hFFFF) bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    // Pipeline register; data fields always follow ID, only control is squashed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q       <= BUBBLE_CTRL;
            pc4_q        <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            funct_q      <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            pc4_q        <= bus_io.id_pc4_i;
            rs_data_q    <= bus_io.id_rs_data_i;
            rt_data_q    <= bus_io.id_rt_data_i;
            imm_q        <= bus_io.id_imm_i;
            rs_q         <= bus_io.id_rs_i;
            rt_q         <= bus_io.id_rt_i;
            rd_q         <= bus_io.id_rd_i;
            funct_q      <= bus_io.id_funct_i;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    // Output drive; stall is suppressed by flush and reset.
    always_comb begin
        bus_io.stall_o      = hazard && !bus_io.flush_i && !rst_i;
        bus_io.ex_ctrl_o    = ctrl_q;
        bus_io.ex_pc4_o     = pc4_q;
        bus_io.ex_rs_data_o = rs_data_q;
        bus_io.ex_rt_data_o = rt_data_q;
        bus_io.ex_imm_o     = imm_q;
        bus_io.ex_rs_o      = rs_q;
        bus_io.ex_rt_o      = rt_q;
        bus_io.ex_rd_o      = rd_q;
        bus_io.ex_funct_o   = funct_q;
        bus_io.bubble_cnt_o = bubble_cnt_q;
        bus_io.flush_cnt_o  = flush_cnt_q;
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: each cycle pushes the expected EX-stage
// contents, then pops and compares after the clock edge.
module tb_id_ex_stage;
    localparam logic [12:0] BUBBLE = 13'h0002;
    localparam logic [12:0] ADD    = 13'h1142;
    localparam logic [12:0] LW     = 13'h1288;

    typedef struct packed {
        logic [12:0] ctrl;
        logic [31:0] pc4, rsd, rtd, imm;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  funct;
        logic [15:0] bcnt, fcnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    id_ex_stage_if io ();

    id_ex_stage dut (.clk_i(clk), .rst_i(rst), .bus_io(io));

    always #5 clk = ~clk;

    vec_t        sb[$];
    logic [15:0] m_bcnt = '0, m_fcnt = '0;
    logic        exp_stall;
    int          vectors = 0, miscompares = 0;

    function automatic vec_t actual();
        vec_t a;
        a.ctrl = io.ex_ctrl_o;    a.pc4 = io.ex_pc4_o;
        a.rsd  = io.ex_rs_data_o; a.rtd = io.ex_rt_data_o; a.imm = io.ex_imm_o;
        a.rs   = io.ex_rs_o;      a.rt  = io.ex_rt_o;      a.rd  = io.ex_rd_o;
        a.funct = io.ex_funct_o;
        a.bcnt = io.bubble_cnt_o; a.fcnt = io.flush_cnt_o;
        return a;
    endfunction

    // Drive one ID-stage instruction and push what EX must hold after the edge.
    // exp_hz is the hazard the test author expects for this cycle.
    task automatic drive(input logic r, input logic fl, input logic [12:0] ctrl,
                         input logic [4:0] rs, input logic [4:0] rt, input logic exp_hz);
        vec_t e;
        rst             = r;
        io.flush_i      = fl;
        io.id_ctrl_i    = ctrl;
        io.id_pc4_i     = $urandom;
        io.id_rs_data_i = $urandom;
        io.id_rt_data_i = $urandom;
        io.id_imm_i     = $urandom;
        io.id_rs_i      = rs;
        io.id_rt_i      = rt;
        io.id_rd_i      = 5'($urandom);
        io.id_funct_i   = 6'($urandom);
        if (r) begin
            e = '0;
            e.ctrl = BUBBLE;
            m_bcnt = '0;
            m_fcnt = '0;
        end else begin
            e.ctrl = (fl || exp_hz) ? BUBBLE : ctrl;
            e.pc4 = io.id_pc4_i; e.rsd = io.id_rs_data_i; e.rtd = io.id_rt_data_i;
            e.imm = io.id_imm_i; e.rs = rs; e.rt = rt; e.rd = io.id_rd_i;
            e.funct = io.id_funct_i;
            if (fl) begin
                if (m_fcnt != 16'hFFFF) m_fcnt = m_fcnt + 16'd1;
            end else if (exp_hz) begin
                if (m_bcnt != 16'hFFFF) m_bcnt = m_bcnt + 16'd1;
            end
        end
        e.bcnt = m_bcnt;
        e.fcnt = m_fcnt;
        sb.push_back(e);
        exp_stall = exp_hz && !fl && !r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vec_t e;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'($urandom), LW, 5'($urandom), 5'($urandom), 1'b0);
            #1;
            vectors++;
            if (io.stall_o !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_stall act=%b exp=0", io.stall_o);
            end
            tick();
            e = sb.pop_front();
            vectors++;
            if (actual() !== e) begin
                miscompares++;
                $display("FAIL reset_out act=%h exp=%h", actual(), e);
            end
        end
    endtask

    // Table-driven cycle runner shared by functional scenarios.
    task automatic test_sequence(input string name, input int n,
                                 input logic [12:0] ctrl[8], input logic [4:0] rs[8],
                                 input logic [4:0] rt[8], input logic fl[8],
                                 input logic hz[8], input logic r[8]);
        vec_t e;
        for (int i = 0; i < n; i++) begin
            drive(r[i], fl[i], ctrl[i], rs[i], rt[i], hz[i]);
            #1;
            vectors++;
            if (io.stall_o !== exp_stall) begin
                miscompares++;
                $display("FAIL %s_stall[%0d] act=%b exp=%b", name, i, io.stall_o, exp_stall);
            end
            tick();
            e = sb.pop_front();
            vectors++;
            if (actual() !== e) begin
                miscompares++;
                $display("FAIL %s_out[%0d] act=%h exp=%h", name, i, actual(), e);
            end
        end
    endtask

    task automatic test_passthrough();
        test_sequence("pass", 2,
            '{ADD, ADD, 0,0,0,0,0,0}, '{5'd1, 5'd3, 0,0,0,0,0,0}, '{5'd2, 5'd4, 0,0,0,0,0,0},
            '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0});
    endtask

    task automatic test_load_use();
        test_sequence("load_use_rs", 4,
            '{LW, ADD, ADD, ADD, 0,0,0,0}, '{5'd1, 5'd8, 5'd8, 5'd3, 0,0,0,0},
            '{5'd8, 5'd2, 5'd2, 5'd4, 0,0,0,0},
            '{0,0,0,0,0,0,0,0}, '{0,1,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0});
        test_sequence("load_use_rt", 3,
            '{LW, ADD, ADD, 0,0,0,0,0}, '{5'd2, 5'd1, 5'd1, 0,0,0,0,0},
            '{5'd9, 5'd9, 5'd9, 0,0,0,0,0},
            '{0,0,0,0,0,0,0,0}, '{0,1,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0});
    endtask

    task automatic test_zero_reg();
        test_sequence("zero_reg", 2,
            '{LW, ADD, 0,0,0,0,0,0}, '{5'd1, 5'd0, 0,0,0,0,0,0}, '{5'd0, 5'd0, 0,0,0,0,0,0},
            '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0});
    endtask

    task automatic test_flush_hazard();
        test_sequence("flush_hz", 4,
            '{LW, ADD, ADD, ADD, 0,0,0,0}, '{5'd1, 5'd1, 5'd1, 5'd6, 0,0,0,0},
            '{5'd5, 5'd5, 5'd5, 5'd7, 0,0,0,0},
            '{0,1,0,1,0,0,0,0}, '{0,1,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0});
    endtask

    task automatic test_reset_mid_stall();
        test_sequence("rst_mid", 3,
            '{LW, ADD, ADD, 0,0,0,0,0}, '{5'd1, 5'd7, 5'd7, 0,0,0,0,0},
            '{5'd7, 5'd2, 5'd2, 0,0,0,0,0},
            '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0}, '{0,1,0,0,0,0,0,0});
    endtask

    task automatic test_back_to_back();
        vec_t e;
        logic [12:0] c;
        for (int i = 0; i < 8; i++) begin
            c = 13'($urandom) & ~13'h0008;
            drive(1'b0, 1'b0, c, 5'($urandom), 5'($urandom), 1'b0);
            tick();
            e = sb.pop_front();
            vectors++;
            if (actual() !== e) begin
                miscompares++;
                $display("FAIL b2b_out[%0d] act=%h exp=%h", i, actual(), e);
            end
        end
    endtask

    task automatic test_saturation();
        vec_t e;
        drive(1'b1, 1'b0, ADD, 5'd0, 5'd0, 1'b0);
        tick();
        void'(sb.pop_front());
        rst = 1'b0;
        io.flush_i = 1'b1;
        io.id_ctrl_i = ADD;
        for (int i = 0; i < 65534; i++) tick();
        m_fcnt = 16'hFFFE;
        vectors++;
        if (io.flush_cnt_o !== 16'hFFFE) begin
            miscompares++;
            $display("FAIL sat_pre act=%h exp=fffe", io.flush_cnt_o);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, LW, 5'd3, 5'd3, 1'b0);
            tick();
            e = sb.pop_front();
            vectors++;
            if (actual() !== e) begin
                miscompares++;
                $display("FAIL sat_out[%0d] act=%h exp=%h", i, actual(), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_use();
        test_zero_reg();
        test_flush_hazard();
        test_reset_mid_stall();
        test_back_to_back();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
